// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Shares one single-port framebuffer RAM (1-cycle read latency)
//                between a VGA scanout prefetcher and a CPU port. The scanout
//                fills a small pixel FIFO. It beats the CPU only when the FIFO
//                is close to running dry (credit < 2). Otherwise the CPU wins
//                and the scanout uses idle RAM cycles.
//  Ports       : clk_i/rst_i       - clock, asynchronous active-high reset
//                frame_start_i     - restart scanout at address 0, flush FIFO
//                pix_ready_i       - pop request from VGA timing
//                pix_data_o/pix_valid_o/underflow_o - FIFO head, non-empty,
//                                    sticky pop-while-empty flag
//                cpu_*             - request/grant CPU port; reads return on
//                                    cpu_rvalid_o one cycle after the grant
//                ram_*             - single-port RAM master interface
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FB_WORDS   = 19200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_start_i,
    input  logic              pix_ready_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_valid_o,
    output logic              underflow_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Two spare bits so occupancy plus one in-flight read never wraps.
    localparam int CNT_W = PTR_W + 2;
    localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  C_URGENT    = CNT_W'(2);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    typedef enum logic [0:0] {
        ST_HOLD = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SCAN = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    state_t            r_state;
    state_t            w_state_nxt;
    tag_t              r_tag;
    tag_t              w_tag_nxt;
    logic [ADDR_W-1:0] r_scan_addr;
    logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_underflow;

    logic [CNT_W-1:0]  w_credit;
    logic              w_empty;
    logic              w_eligible;
    logic              w_urgent;
    logic              w_scan_gnt;
    logic              w_cpu_gnt;
    logic              w_push;
    logic              w_pop;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_empty    = (r_count == '0);
        // Credit counts the read in flight so the FIFO can never overflow.
        w_credit   = r_count + ((r_tag == TAG_SCAN) ? CNT_W'(1) : CNT_W'(0));
        w_eligible = (r_state == ST_SCAN) && (w_credit < C_DEPTH) && !frame_start_i;
        w_urgent   = w_eligible && (w_credit < C_URGENT);
        w_scan_gnt = 1'b0;
        w_cpu_gnt  = 1'b0;
        // Grants are combinational, so they are masked while reset is held.
        if (!rst_i) begin
            if (w_urgent) begin
                w_scan_gnt = 1'b1;
            end else if (cpu_req_i) begin
                w_cpu_gnt = 1'b1;
            end else if (w_eligible) begin
                w_scan_gnt = 1'b1;
            end
        end
        // A scan read returning during frame_start belongs to the old frame.
        w_push = (r_tag == TAG_SCAN) && !frame_start_i;
        w_pop  = pix_ready_i && !w_empty && !frame_start_i;
    end

    // ------------------------------------------------------------------
    // FSM next state and in-flight tag
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tag_nxt   = TAG_NONE;
        if (frame_start_i) begin
            w_state_nxt = ST_SCAN;
        end else if (w_scan_gnt && (r_scan_addr == C_LAST_ADDR)) begin
            w_state_nxt = ST_HOLD;
        end
        if (w_scan_gnt) begin
            w_tag_nxt = TAG_SCAN;
        end else if (w_cpu_gnt && !cpu_we_i) begin
            w_tag_nxt = TAG_CPU;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_HOLD;
            r_tag   <= TAG_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= w_tag_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scan address, FIFO control, underflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scan_addr <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (pix_ready_i && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (frame_start_i) begin
                r_scan_addr <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
            end else begin
                if (w_scan_gnt) begin
                    r_scan_addr <= r_scan_addr + ADDR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= ram_rdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ram_en_o     = w_scan_gnt || w_cpu_gnt;
        ram_we_o     = w_cpu_gnt && cpu_we_i;
        ram_addr_o   = w_cpu_gnt ? cpu_addr_i : r_scan_addr;
        ram_wdata_o  = (w_cpu_gnt && cpu_we_i) ? cpu_wdata_i : '0;
        cpu_gnt_o    = w_cpu_gnt;
        cpu_rvalid_o = (r_tag == TAG_CPU);
        cpu_rdata_o  = (r_tag == TAG_CPU) ? ram_rdata_i : '0;
        pix_valid_o  = !w_empty;
        pix_data_o   = w_empty ? '0 : r_fifo[r_rd_ptr];
        underflow_o  = r_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_fb_arbiter
//  Description : Self-checking bench for vga_fb_arbiter. A RAM model answers
//                the RAM port. A monitor scoreboards pixels, CPU read data
//                and scan addresses against a frame-level reference model.
//                Directed scenarios are followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 12;
    localparam int FBW = 16;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          underflow;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FB_WORDS   (FBW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_start_i (frame_start),
        .pix_ready_i   (pix_ready),
        .pix_data_o    (pix_data),
        .pix_valid_o   (pix_valid),
        .underflow_o   (underflow),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_gnt_o     (cpu_gnt),
        .cpu_rvalid_o  (cpu_rvalid),
        .cpu_rdata_o   (cpu_rdata),
        .ram_en_o      (ram_en),
        .ram_we_o      (ram_we),
        .ram_addr_o    (ram_addr),
        .ram_wdata_o   (ram_wdata),
        .ram_rdata_i   (ram_rdata)
    );

    // Power-up RAM contents: distinct, non-zero values for the frame region.
    function automatic logic [DW-1:0] init_val(input int a);
        int v;
        v = (a * 37 + 11) % 4096;
        return DW'(v);
    endfunction

    // Single-port RAM, 1-cycle read latency; only written words are stored.
    logic [DW-1:0] ram_wr [int];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_wr[int'(ram_addr)] = ram_wdata;
            end else begin
                ram_rdata <= ram_wr.exists(int'(ram_addr)) ? ram_wr[int'(ram_addr)]
                                                           : init_val(int'(ram_addr));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and monitor
    // ------------------------------------------------------------------
    logic [DW-1:0] wr_model [int];
    logic [DW-1:0] exp_pix [$];
    logic [DW-1:0] exp_rd  [$];
    logic [DW-1:0] exp_val;
    int            exp_scan = 0;
    bit            rd_prev  = 1'b0;
    bit            last_gnt = 1'b0;
    int            n_scan = 0;
    int            n_pix  = 0;
    int            n_rv   = 0;
    int            n_en   = 0;

    function automatic logic [DW-1:0] model_val(input int a);
        return wr_model.exists(a) ? wr_model[a] : init_val(a);
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_pix.delete();
            exp_rd.delete();
            exp_scan = 0;
            rd_prev  = 1'b0;
            last_gnt = 1'b0;
        end else begin
            if (ram_en) n_en++;
            // CPU read return: exactly one cycle after a read grant.
            if (rd_prev) begin
                exp_val = exp_rd.pop_front();
                n_rv++;
                check("cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
                check("cpu_rdata", {20'd0, cpu_rdata}, {20'd0, exp_val});
            end else if (cpu_rvalid) begin
                n_rv++;
                check("cpu_rvalid_spurious", {31'd0, cpu_rvalid}, 32'd0);
            end
            // Frame start: the whole frame is expected again from address 0.
            if (frame_start) begin
                exp_pix.delete();
                for (int i = 0; i < FBW; i++) exp_pix.push_back(model_val(i));
                exp_scan = 0;
            end else if (pix_ready) begin
                if (pix_valid) begin
                    n_pix++;
                    check("pixel_expected", {31'd0, exp_pix.size() > 0}, 32'd1);
                    if (exp_pix.size() > 0) begin
                        exp_val = exp_pix.pop_front();
                        check("pixel", {20'd0, pix_data}, {20'd0, exp_val});
                    end
                end else begin
                    check("empty_pix_data_zero", {20'd0, pix_data}, 32'd0);
                end
            end
            rd_prev = 1'b0;
            if (cpu_gnt) begin
                check("cpu_gnt_ram",
                      {8'd0, ram_en, ram_we, ram_addr, (cpu_we ? ram_wdata : DW'(0))},
                      {8'd0, 1'b1, cpu_we, cpu_addr, (cpu_we ? cpu_wdata : DW'(0))});
                if (cpu_we) begin
                    wr_model[int'(cpu_addr)] = cpu_wdata;
                end else begin
                    exp_rd.push_back(model_val(int'(cpu_addr)));
                    rd_prev = 1'b1;
                end
            end else if (ram_en) begin
                n_scan++;
                check("scan_is_read", {31'd0, ram_we}, 32'd0);
                check("scan_in_frame", {31'd0, exp_scan < FBW}, 32'd1);
                check("scan_addr", {22'd0, ram_addr}, {22'd0, exp_scan[AW-1:0]});
                exp_scan++;
            end
            last_gnt = cpu_gnt;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {19'd0, ram_en, ram_we, cpu_gnt, cpu_rvalid, pix_valid, underflow, 1'b0, pix_data},
                    32'd0);
    endtask

    task automatic pulse_frame_start();
        step();
        frame_start = 1'b1;
        pix_ready   = 1'b0;
        step();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        step();
        step();
        rst = 1'b0;
    endtask

    int  s0, e0, p0, r0, cyc, max_wait, wait_cnt;
    bit  got;

    initial begin
        // Reset with a CPU write request and pop pending: nothing may leak out.
        idle_inputs();
        rst       = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        check_reset_outputs("por_outputs");
        step();
        step();
        idle_inputs();
        rst = 1'b0;

        // A: no access before frame start, then exactly FD prefetch reads.
        @(negedge clk); #1;
        e0 = n_en;
        repeat (5) step();
        @(negedge clk); #1;
        check("a_no_access_before_start", e0 - n_en, 32'd0);
        s0 = n_scan;
        pulse_frame_start();
        repeat (10) step();
        @(negedge clk); #1;
        check("a_scan_reads", n_scan - s0, FD);
        check("a_fifo_valid", {31'd0, pix_valid}, 32'd1);
        check("a_ram_idle", {31'd0, ram_en}, 32'd0);
        check("a_head_pixel", {20'd0, pix_data}, {20'd0, init_val(0)});

        // B: FIFO holds 3, CPU read of 0x100 is granted immediately.
        step();
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = AW'(16'h100);
        @(negedge clk);
        check("b_gnt_at_once", {31'd0, cpu_gnt}, 32'd1);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("b_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("b_rdata", {20'd0, cpu_rdata}, {20'd0, init_val(256)});

        // C: empty FIFO, CPU waiting, pops every cycle. Credit is 0, then 1
        // (one read in flight), then 2 (one pixel + one in flight): the
        // CPU wins on the third cycle after two scan reads.
        step();
        frame_start = 1'b1;
        @(negedge clk); #1;
        s0 = n_scan;
        step();
        frame_start = 1'b0;
        pix_ready   = 1'b1;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = AW'(16'h155);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
            if (cpu_gnt) got = 1'b1;
            else step();
        end
        check("c_gnt_seen", {31'd0, got}, 32'd1);
        check("c_gnt_cycle", cyc, 32'd3);
        check("c_scans_before_gnt", n_scan - s0, 32'd2);
        step();
        cpu_req   = 1'b0;
        pix_ready = 1'b0;

        // D: one whole frame popped continuously, then HOLD and underflow.
        do_reset();
        @(negedge clk);
        check("d_underflow_cleared", {31'd0, underflow}, 32'd0);
        @(negedge clk); #1;
        s0 = n_scan;
        pulse_frame_start();
        repeat (10) step();
        @(negedge clk); #1;
        p0 = n_pix;
        step();
        pix_ready = 1'b1;
        for (int i = 0; i < FBW; i++) begin
            @(negedge clk);
            check("d_valid_while_popping", {31'd0, pix_valid}, 32'd1);
            step();
        end
        pix_ready = 1'b0;
        @(negedge clk); #1;
        e0 = n_en;
        repeat (5) step();
        @(negedge clk); #1;
        check("d_pixel_count", n_pix - p0, FBW);
        check("d_scan_total", n_scan - s0, FBW);
        check("d_hold_no_reads", n_en - e0, 32'd0);
        check("d_fifo_empty", {31'd0, pix_valid}, 32'd0);
        check("d_no_underflow_yet", {31'd0, underflow}, 32'd0);
        step();
        pix_ready = 1'b1;
        step();
        pix_ready = 1'b0;
        @(negedge clk);
        check("d_underflow_17th_pop", {31'd0, underflow}, 32'd1);

        // E: frame_start the cycle after the scan grant of address 1;
        // both stale pixels must vanish and RAM[0] must come out first.
        pulse_frame_start();
        step();
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        @(negedge clk);
        check("e_flushed", {31'd0, pix_valid}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (pix_valid) got = 1'b1;
            else step();
        end
        check("e_valid_seen", {31'd0, got}, 32'd1);
        check("e_first_pixel", {20'd0, pix_data}, {20'd0, init_val(0)});
        step();
        pix_ready = 1'b1;
        repeat (4) step();
        pix_ready = 1'b0;

        // F: reset one cycle after a CPU read grant.
        step();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = AW'(16'h2AA);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (cpu_gnt) got = 1'b1;
            else step();
        end
        check("f_gnt_seen", {31'd0, got}, 32'd1);
        step();
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("f_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check_reset_outputs("f_reset_outputs");
        step();
        step();
        rst = 1'b0;
        @(negedge clk); #1;
        r0 = n_rv;
        e0 = n_en;
        repeat (6) step();
        @(negedge clk); #1;
        check("f_no_rvalid_after_reset", n_rv - r0, 32'd0);
        check("f_no_access_after_reset", n_en - e0, 32'd0);
        check("f_no_push_after_reset", {31'd0, pix_valid}, 32'd0);

        // Randomized traffic; CPU writes stay outside the frame region.
        pulse_frame_start();
        max_wait = 0;
        wait_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            if (cpu_req && last_gnt) cpu_req = 1'b0;
            if (cpu_req) begin
                wait_cnt++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
            end else if ($urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = cpu_we ? AW'($urandom_range(FBW, (1 << AW) - 1))
                                   : AW'($urandom_range(0, (1 << AW) - 1));
                cpu_wdata = DW'($urandom);
                wait_cnt  = 0;
            end
            if ($urandom_range(0, 79) == 0) begin
                frame_start = 1'b1;
                pix_ready   = 1'b0;
            end else begin
                frame_start = 1'b0;
                pix_ready   = 1'($urandom_range(0, 1));
            end
            step();
        end
        check("r_cpu_wait_bounded", {31'd0, max_wait < 50}, 32'd1);
        idle_inputs();
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
